// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: run-controlled programmable serial pattern matcher.
// Counts pattern hits over a window of valid samples; every output is registered.
module seq_match_ctrl #(
   parameter int MAXLEN = 8,
   parameter int LENW   = 4,
   parameter int WINW   = 16,
   parameter int CNTW   = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cfg_we,
   input  logic [MAXLEN-1:0] cfg_pattern,
   input  logic [LENW-1:0]   cfg_len,
   input  logic              cfg_overlap,
   input  logic              start,
   input  logic [WINW-1:0]   window_len,
   input  logic              x_valid,
   input  logic              x,
   output logic              busy,
   output logic              match,
   output logic [CNTW-1:0]   match_count,
   output logic              done,
   output logic              cfg_err,
   output logic              dbg_state
);

   // Handshake: start is a one-cycle request honoured only in IDLE; x is consumed
   // on every RUN cycle with x_valid=1 (no backpressure, so no ready signal).
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);

   state_t            state, state_d;
   logic [MAXLEN-1:0] pattern, pattern_d;
   logic [LENW-1:0]   len, len_d;
   logic              overlap, overlap_d;
   logic [MAXLEN-1:0] history, history_d;
   logic [LENW-1:0]   fill, fill_d;
   logic [WINW-1:0]   remaining, remaining_d;
   logic [CNTW-1:0]   count_d;
   logic              busy_d, match_d, done_d, cfg_err_d;

   logic              cfg_load;
   logic [MAXLEN-1:0] hist_new;
   logic [MAXLEN-1:0] len_mask;
   logic              hit;
   logic              last_sample;

   assign dbg_state   = state;
   assign cfg_load    = cfg_we && (state == IDLE) && (cfg_len != '0) && (cfg_len <= MAXLEN_L);
   assign hist_new    = {history[MAXLEN-2:0], x};
   assign len_mask    = ~({MAXLEN{1'b1}} << len);
   // fill counts bits gathered since run start or the last non-overlapping hit
   assign hit         = (({1'b0, fill} + (LENW+1)'(1)) >= {1'b0, len}) &&
                        (((hist_new ^ pattern) & len_mask) == '0);
   assign last_sample = x_valid && (remaining == WINW'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start && (window_len != '0)) state_d = RUN;
         RUN:     if (last_sample) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pattern_d   = pattern;
      len_d       = len;
      overlap_d   = overlap;
      history_d   = history;
      fill_d      = fill;
      remaining_d = remaining;
      count_d     = match_count;
      busy_d      = busy;
      match_d     = 1'b0;
      done_d      = 1'b0;
      cfg_err_d   = cfg_we && !cfg_load;
      if (cfg_load) begin
         pattern_d = cfg_pattern;
         len_d     = cfg_len;
         overlap_d = cfg_overlap;
      end
      case (state)
         IDLE: begin
            if (start) begin
               count_d = '0;
               if (window_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  history_d   = '0;
                  fill_d      = '0;
                  remaining_d = window_len;
                  busy_d      = 1'b1;
               end
            end
         end
         RUN: begin
            if (x_valid) begin
               history_d   = hist_new;
               remaining_d = remaining - WINW'(1);
               fill_d      = (fill == MAXLEN_L) ? fill : fill + LENW'(1);
               if (hit) begin
                  match_d = 1'b1;
                  if (match_count != '1) count_d = match_count + CNTW'(1);
                  if (!overlap) fill_d = '0;
               end
               if (last_sample) begin
                  done_d = 1'b1;
                  busy_d = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pattern     <= '0;
         len         <= LENW'(1);
         overlap     <= 1'b1;
         history     <= '0;
         fill        <= '0;
         remaining   <= '0;
         match_count <= '0;
         busy        <= 1'b0;
         match       <= 1'b0;
         done        <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         pattern     <= pattern_d;
         len         <= len_d;
         overlap     <= overlap_d;
         history     <= history_d;
         fill        <= fill_d;
         remaining   <= remaining_d;
         match_count <= count_d;
         busy        <= busy_d;
         match       <= match_d;
         done        <= done_d;
         cfg_err     <= cfg_err_d;
      end
   end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Bench for seq_match_ctrl: directed scenarios plus randomized runs, checked every
// cycle against a bit-queue model of the matcher.
module tb_seq_match_ctrl;
   localparam int MAXLEN = 8;
   localparam int LENW   = 4;
   localparam int WINW   = 16;
   localparam int CNTW   = 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              cfg_we = 1'b0;
   logic [MAXLEN-1:0] cfg_pattern = '0;
   logic [LENW-1:0]   cfg_len = '0;
   logic              cfg_overlap = 1'b0;
   logic              start = 1'b0;
   logic [WINW-1:0]   window_len = '0;
   logic              x_valid = 1'b0;
   logic              x = 1'b0;
   logic              busy, match, done, cfg_err, dbg_state;
   logic [CNTW-1:0]   match_count;

   int checks = 0;
   int failures = 0;

   // reference model state
   bit                m_run;
   int                m_rem;
   logic [MAXLEN-1:0] m_pat;
   int                m_len;
   bit                m_ovl;
   bit                bits_q[$];
   logic              e_busy, e_match, e_done, e_err;
   int                e_count;
   logic [CNTW-1:0]   exp_q[$];

   int match_seen = 0, done_seen = 0, busy_seen = 0, err_seen = 0;

   seq_match_ctrl #(.MAXLEN(MAXLEN), .LENW(LENW), .WINW(WINW), .CNTW(CNTW)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start),
      .window_len(window_len), .x_valid(x_valid), .x(x), .busy(busy),
      .match(match), .match_count(match_count), .done(done), .cfg_err(cfg_err),
      .dbg_state(dbg_state)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_rem = 0; m_pat = '0; m_len = 1; m_ovl = 1;
      bits_q.delete();
      e_busy = 0; e_match = 0; e_done = 0; e_err = 0; e_count = 0;
   endtask

   // Next-cycle outputs from the inputs present at this clock edge.
   task automatic model_step();
      bit ok, hit;
      e_match = 0; e_done = 0;
      ok = cfg_we && !m_run && cfg_len >= 1 && cfg_len <= MAXLEN;
      e_err = cfg_we && !ok;
      if (ok) begin m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; end
      if (!m_run) begin
         if (start) begin
            e_count = 0;
            if (window_len == 0) begin
               e_done = 1;
               exp_q.push_back(CNTW'(0));
            end else begin
               m_run = 1; m_rem = int'(window_len); bits_q.delete();
            end
         end
      end else if (x_valid) begin
         bits_q.push_back(x);
         if (bits_q.size() > MAXLEN) void'(bits_q.pop_front());
         hit = bits_q.size() >= m_len;
         for (int i = 0; i < m_len; i++)
            if (hit && bits_q[bits_q.size()-1-i] != m_pat[i]) hit = 0;
         if (hit) begin
            e_match = 1;
            if (e_count < 255) e_count++;
            if (!m_ovl) bits_q.delete();
         end
         m_rem--;
         if (m_rem == 0) begin
            m_run = 0; e_done = 1;
            exp_q.push_back(CNTW'(e_count));
         end
      end
      e_busy = m_run;
   endtask

   // compare process: every negedge
   initial forever begin
      @(negedge clk);
      chk("busy", busy, e_busy);
      chk("match", match, e_match);
      chk("done", done, e_done);
      chk("cfg_err", cfg_err, e_err);
      chk("match_count", match_count, e_count);
      chk("state", dbg_state, e_busy);
      if (match) match_seen++;
      if (busy) busy_seen++;
      if (cfg_err) err_seen++;
      if (done) begin
         done_seen++;
         if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
         else chk("done_count", match_count, exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic cfg(input logic [MAXLEN-1:0] pat, input int len, input bit ovl);
      cfg_we = 1; cfg_pattern = pat; cfg_len = LENW'(len); cfg_overlap = ovl;
      tick();
      cfg_we = 0;
   endtask

   task automatic start_run(input int win);
      start = 1; window_len = WINW'(win);
      tick();
      start = 0;
   endtask

   task automatic sample(input bit v, input bit b);
      x_valid = v; x = b;
      tick();
      x_valid = 0;
   endtask

   initial begin
      int sm, sd, sb, se;
      logic [6:0] s1;
      logic [3:0] s4;
      logic [4:0] s5;
      model_reset();
      repeat (3) @(posedge clk);
      #2 reset_n = 1;
      settle();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", match_count, 0);
      chk("rst_model_len", m_len, 1);

      // 1101 overlapping over stream 1101101
      s1 = 7'b1101101;
      cfg(8'b1101, 4, 1);
      sm = match_seen; sd = done_seen;
      start_run(7);
      for (int i = 6; i >= 0; i--) sample(1, s1[i]);
      settle();
      chk("ovl_model_count", e_count, 2);
      chk("ovl_count", match_count, 2);
      chk("ovl_match_pulses", match_seen - sm, 2);
      chk("ovl_done_pulses", done_seen - sd, 1);
      chk("ovl_busy", busy, 0);

      // same stream, non-overlapping
      cfg(8'b1101, 4, 0);
      sm = match_seen;
      start_run(7);
      for (int i = 6; i >= 0; i--) sample(1, s1[i]);
      settle();
      chk("novl_model_count", e_count, 1);
      chk("novl_count", match_count, 1);
      chk("novl_match_pulses", match_seen - sm, 1);

      // saturation
      cfg(8'b1, 1, 1);
      sd = done_seen;
      start_run(300);
      for (int i = 0; i < 300; i++) sample(1, 1);
      settle();
      chk("sat_count", match_count, 255);
      chk("sat_model_count", e_count, 255);
      chk("sat_done_pulses", done_seen - sd, 1);

      // zero window
      sd = done_seen; sb = busy_seen;
      start_run(0);
      settle();
      chk("win0_done_pulses", done_seen - sd, 1);
      chk("win0_count", match_count, 0);
      tick();
      settle();
      chk("win0_busy_cycles", busy_seen - sb, 0);

      // rejected configs: length 9, then a write during a run
      cfg(8'b1101, 4, 1);
      se = err_seen; sm = match_seen;
      cfg(8'hFF, 9, 0);
      start_run(6);
      sample(1, 1);
      cfg_we = 1; cfg_pattern = 8'h00; cfg_len = 4'd2; x_valid = 1; x = 1;
      tick();
      cfg_we = 0; x_valid = 0;
      sample(1, 0); sample(1, 1); sample(1, 0); sample(1, 0);
      settle();
      chk("err_pulses", err_seen - se, 2);
      chk("err_count", match_count, 1);
      chk("err_match_pulses", match_seen - sm, 1);

      // reset in the middle of a run
      sd = done_seen;
      start_run(10);
      sample(1, 1); sample(1, 0); sample(1, 1);
      reset_n = 0;
      model_reset();
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_match", match, 0);
      chk("mid_rst_count", match_count, 0);
      chk("mid_rst_state", dbg_state, 0);
      @(posedge clk);
      #2 reset_n = 1;
      settle();
      chk("mid_rst_no_done", done_seen - sd, 0);
      s5 = 5'b10010;
      start_run(5);
      for (int i = 4; i >= 0; i--) sample(1, s5[i]);
      settle();
      chk("dflt_count", match_count, 3);

      // valid gaps
      s4 = 4'b1101;
      cfg(8'b1101, 4, 1);
      sd = done_seen;
      start_run(4);
      for (int i = 3; i >= 0; i--) begin
         sample(0, 1'($urandom_range(0, 1)));
         if (i == 0) begin settle(); chk("gap_busy_before_last", busy, 1); end
         sample(1, s4[i]);
      end
      sample(0, 1);
      settle();
      chk("gap_count", match_count, 1);
      chk("gap_done_pulses", done_seen - sd, 1);

      // randomized runs
      for (int r = 0; r < 40; r++) begin
         int n;
         cfg_we = 1; cfg_pattern = MAXLEN'($urandom_range(0, 255));
         cfg_len = LENW'($urandom_range(0, 10)); cfg_overlap = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            tick();
            cfg_we = 0;
         end
         start = 1; window_len = WINW'($urandom_range(0, 40));
         tick();
         cfg_we = 0; start = 0;
         n = 0;
         while (m_run && n < 400) begin
            x_valid = ($urandom_range(0, 3) != 0);
            x = 1'($urandom_range(0, 1));
            cfg_we = ($urandom_range(0, 9) == 0);
            cfg_len = LENW'($urandom_range(0, 10));
            start = ($urandom_range(0, 19) == 0);
            tick();
            x_valid = 0; cfg_we = 0; start = 0;
            n++;
         end
         chk("rand_run_ended", m_run, 0);
         tick();
      end

      settle();
      chk("exp_q_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
